mem_responder: RTL and testbench

//   Memory-side responder for the core's load/store accesses. Accepts one word

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's load/store path and mem_responder.
//   master: drives req_valid/req_wr/req_addr/req_wdata and observes the rest.
//   slave : drives req_ready/resp_valid/resp_rdata/resp_err/busy.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_wr;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word read/write at a time, waits
// WAIT_CYCLES cycles, then issues a one-cycle response (read data or error).
// Holds a word-addressed array of 2**ADDR_W words (contents not reset).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of mem_responder_if (request in, response/status out)
module mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept_c;
  logic                illegal_c;
  logic                acc_c;
  logic                acc_direct_c;
  logic                acc_wr_c;
  logic [ADDR_W-1:0]   acc_idx_c;
  logic [DATA_W-1:0]   acc_wdata_c;
  logic [DATA_W-1:0]   acc_rdata_c;

  // Accept/legality decode and selection of the access operands.
  // With zero wait states the access uses the request as presented;
  // otherwise it uses the copy latched at accept.
  always_comb begin
    accept_c     = bus.req_valid && req_ready_q;
    illegal_c    = (bus.req_addr[1:0] != 2'b00) ||
                   ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
    acc_direct_c = ZERO_WAIT && (state_q == S_IDLE) && accept_c && !illegal_c;
    acc_c        = acc_direct_c || ((state_q == S_WAIT) && (cnt_q == '0));
    acc_wr_c     = acc_direct_c ? bus.req_wr                     : wr_q;
    acc_idx_c    = acc_direct_c ? bus.req_addr[ADDR_W+1:2]       : idx_q;
    acc_wdata_c  = acc_direct_c ? bus.req_wdata                  : wdata_q;
    acc_rdata_c  = acc_wr_c ? '0 : mem[acc_idx_c];
  end

  // Storage array; a reset while a write is pending leaves it untouched
  // because the FSM is forced out of WAIT before the access edge.
  always_ff @(posedge clk) begin
    if (acc_c && acc_wr_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            wr_q        <= bus.req_wr;
            idx_q       <= bus.req_addr[ADDR_W+1:2];
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (illegal_c) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (ZERO_WAIT) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= acc_rdata_c;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= acc_rdata_c;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: dut0 with WAIT_CYCLES=2, dut1 with WAIT_CYCLES=0,
// sharing clock and reset. A transaction-level model predicts every output
// each cycle; directed requests add hand-computed literal expectations.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(32)) if0 ();
  mem_responder_if #(.DATA_W(32)) if1 ();

  mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  // ---------------- access helpers ----------------
  task automatic drive(input int d, input logic v, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_wr = wr; if0.req_addr = a; if0.req_wdata = wd;
    end else begin
      if1.req_valid = v; if1.req_wr = wr; if1.req_addr = a; if1.req_wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? if0.req_ready : if1.req_ready;
  endfunction
  function automatic logic get_valid(input int d);
    return (d == 0) ? if0.resp_valid : if1.resp_valid;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? if0.resp_err : if1.resp_err;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? if0.resp_rdata : if1.resp_rdata;
  endfunction
  function automatic logic in_valid(input int d);
    return (d == 0) ? if0.req_valid : if1.req_valid;
  endfunction
  function automatic logic in_wr(input int d);
    return (d == 0) ? if0.req_wr : if1.req_wr;
  endfunction
  function automatic logic [31:0] in_addr(input int d);
    return (d == 0) ? if0.req_addr : if1.req_addr;
  endfunction
  function automatic logic [31:0] in_wdata(input int d);
    return (d == 0) ? if0.req_wdata : if1.req_wdata;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // ---------------- transaction-level model ----------------
  // A request is accepted when the block is ready; a legal one answers
  // WAIT_CYCLES edges after the accept edge, an illegal one on the accept
  // edge itself; the block is ready again one edge after the answer.
  logic        m_ready [2];
  logic        m_valid [2];
  logic        m_err   [2];
  logic        m_busy  [2];
  logic [31:0] m_rdata [2];
  bit          m_pend  [2];
  bit          m_cool  [2];
  int          m_due   [2];
  bit          p_wr    [2];
  bit          p_bad   [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [31:0] mm [int];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ready[d] = 1'b1; m_valid[d] = 1'b0; m_err[d] = 1'b0;
        m_busy[d] = 1'b0; m_rdata[d] = 32'd0; m_pend[d] = 1'b0; m_cool[d] = 1'b0;
      end else begin
        m_valid[d] = 1'b0;
        m_err[d]   = 1'b0;
        if (m_cool[d]) begin
          m_cool[d] = 1'b0; m_ready[d] = 1'b1; m_busy[d] = 1'b0;
        end else if (m_pend[d]) begin
          m_due[d] = m_due[d] - 1;
        end else if (m_ready[d] && in_valid(d)) begin
          p_wr[d]    = in_wr(d);
          p_addr[d]  = in_addr(d);
          p_wdata[d] = in_wdata(d);
          p_bad[d]   = (p_addr[d] % 4 != 0) || (p_addr[d] >= 32'd1024);
          m_pend[d]  = 1'b1;
          m_due[d]   = p_bad[d] ? 0 : wait_of(d);
          m_ready[d] = 1'b0;
          m_busy[d]  = 1'b1;
        end
        if (m_pend[d] && m_due[d] == 0) begin
          m_pend[d]  = 1'b0;
          m_cool[d]  = 1'b1;
          m_valid[d] = 1'b1;
          m_err[d]   = p_bad[d];
          if (p_bad[d]) begin
            m_rdata[d] = 32'd0;
          end else if (p_wr[d]) begin
            m_rdata[d] = 32'd0;
            mm[d * 4096 + int'(p_addr[d])] = p_wdata[d];
          end else begin
            m_rdata[d] = mm.exists(d * 4096 + int'(p_addr[d])) ?
                         mm[d * 4096 + int'(p_addr[d])] : 32'hxxxxxxxx;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic issue(input int d, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    @(negedge clk);
    drive(d, 1'b1, wr, a, wd);
    n = 0;
    while (!get_ready(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", d, 32'(get_ready(d)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic collect(input int d, output logic [31:0] rd, output logic er,
                         output int lat);
    lat = 1;
    while (!get_valid(d) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("resp_timeout", d, 32'(get_valid(d)), 32'd1);
    rd = get_rdata(d);
    er = get_err(d);
  endtask

  task automatic do_req(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    issue(d, wr, a, wd);
    collect(d, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  longint      t_acc [3];
  logic [31:0] seq_addr [3];

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 rst = 1'b1;
    #21 rst = 1'b0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          check("ready", d, 32'(get_ready(d)), 32'(m_ready[d]));
          check("busy",  d, 32'(get_busy(d)),  32'(m_busy[d]));
          check("valid", d, 32'(get_valid(d)), 32'(m_valid[d]));
          check("rdata", d, get_rdata(d), m_rdata[d]);
          if (m_valid[d]) check("err", d, 32'(get_err(d)), 32'(m_err[d]));
        end
      end
    join_none

    @(negedge clk);
    check("rst_ready", 0, 32'(get_ready(0)), 32'd1);
    check("rst_busy",  0, 32'(get_busy(0)),  32'd0);
    check("rst_valid", 0, 32'(get_valid(0)), 32'd0);
    check("rst_rdata", 0, get_rdata(0), 32'd0);

    // Known contents for later reads.
    do_req(0, 1'b1, 32'h000, 32'h1111_1111, rd, er, lat);
    do_req(0, 1'b1, 32'h004, 32'h2222_2222, rd, er, lat);
    do_req(0, 1'b1, 32'h008, 32'h3333_3333, rd, er, lat);
    do_req(0, 1'b1, 32'h020, 32'h0BAD_F00D, rd, er, lat);
    do_req(0, 1'b1, 32'h3FC, 32'hCAFE_F00D, rd, er, lat);
    do_req(1, 1'b1, 32'h000, 32'h0000_00A0, rd, er, lat);
    do_req(1, 1'b1, 32'h004, 32'h0000_00A4, rd, er, lat);
    do_req(1, 1'b1, 32'h008, 32'h0000_00A8, rd, er, lat);

    // Legal write then read-back, latency WAIT_CYCLES edges after accept.
    do_req(0, 1'b1, 32'h010, 32'hDEAD_BEEF, rd, er, lat);
    check("wr10_lat", 0, 32'(lat), 32'd3);
    check("wr10_err", 0, 32'(er), 32'd0);
    check("wr10_rdata", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h010, 32'd0, rd, er, lat);
    check("rd10_lat", 0, 32'(lat), 32'd3);
    check("rd10_err", 0, 32'(er), 32'd0);
    check("rd10_rdata", 0, rd, 32'hDEAD_BEEF);

    // Mid-cycle asynchronous reset while a read waits.
    issue(0, 1'b0, 32'h010, 32'd0);
    check("pre_rst_busy", 0, 32'(get_busy(0)), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_ready", 0, 32'(get_ready(0)), 32'd1);
    check("async_valid", 0, 32'(get_valid(0)), 32'd0);
    check("async_rdata", 0, get_rdata(0), 32'd0);
    check("async_busy",  0, 32'(get_busy(0)),  32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Misaligned write: error after one edge, array untouched.
    do_req(0, 1'b1, 32'h013, 32'h1234_5678, rd, er, lat);
    check("mis_lat", 0, 32'(lat), 32'd1);
    check("mis_err", 0, 32'(er), 32'd1);
    check("mis_rdata", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h010, 32'd0, rd, er, lat);
    check("rd10_after_mis", 0, rd, 32'hDEAD_BEEF);

    // Range boundary.
    do_req(0, 1'b0, 32'h400, 32'd0, rd, er, lat);
    check("oor_err", 0, 32'(er), 32'd1);
    check("oor_lat", 0, 32'(lat), 32'd1);
    check("oor_rdata", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h3FC, 32'd0, rd, er, lat);
    check("last_err", 0, 32'(er), 32'd0);
    check("last_rdata", 0, rd, 32'hCAFE_F00D);

    // Reset during WAIT discards the write and its response.
    issue(0, 1'b1, 32'h020, 32'hAAAA_5555);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_resp", 0, 32'(get_valid(0)), 32'd0);
    end
    do_req(0, 1'b0, 32'h020, 32'd0, rd, er, lat);
    check("rd20_kept", 0, rd, 32'h0BAD_F00D);
    check("rd20_err", 0, 32'(er), 32'd0);

    // Back-to-back reads with req_valid held high.
    seq_addr[0] = 32'h0; seq_addr[1] = 32'h4; seq_addr[2] = 32'h8;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        int n;
        @(negedge clk);
        drive(d, 1'b1, 1'b0, seq_addr[k], 32'd0);
        n = 0;
        while (!get_ready(d) && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("seq_accept", d, 32'(get_ready(d)), 32'd1);
        @(posedge clk);
        t_acc[k] = longint'($time);
      end
      @(negedge clk);
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
      check("gap01", d, 32'((t_acc[1] - t_acc[0]) / 10), (d == 0) ? 32'd4 : 32'd2);
      check("gap12", d, 32'((t_acc[2] - t_acc[1]) / 10), (d == 0) ? 32'd4 : 32'd2);
      repeat (6) @(negedge clk);
    end

    // Zero-wait instance: legal read answers on the accept edge.
    do_req(1, 1'b0, 32'h004, 32'd0, rd, er, lat);
    check("w0_lat", 1, 32'(lat), 32'd1);
    check("w0_rdata", 1, rd, 32'h0000_00A4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
